// File: rtl/waveform_pkg.sv
// Shared definitions for the waveform sequencer: pattern codes, FSM encoding
// and the default dwell counter width.
package waveform_pkg;

   localparam logic [1:0] PAT_0 = 2'b00;
   localparam logic [1:0] PAT_1 = 2'b01;
   localparam logic [1:0] PAT_2 = 2'b10;
   localparam logic [1:0] PAT_3 = 2'b11;

   localparam int DW_DEFAULT = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/waveform_seq_table.sv
// Step table for the sequencer: DEPTH entries of {pattern, dwell},
// synchronous write, combinational read, cleared by reset.
module waveform_seq_table import waveform_pkg::*; #(
   parameter int DEPTH = 4,
   parameter int AW    = 2,
   parameter int DW    = DW_DEFAULT
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          we,
   input  logic [AW-1:0] wr_addr,
   input  logic [1:0]    wr_pattern,
   input  logic [DW-1:0] wr_dwell,
   input  logic [AW-1:0] rd_addr,
   output logic [1:0]    rd_pattern,
   output logic [DW-1:0] rd_dwell
);

   logic [1:0]    pattern_q [DEPTH];
   logic [DW-1:0] dwell_q   [DEPTH];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            pattern_q[i] <= PAT_0;
            dwell_q[i]   <= '0;
         end
      end else if (we) begin
         pattern_q[wr_addr] <= wr_pattern;
         dwell_q[wr_addr]   <= wr_dwell;
      end
   end

   assign rd_pattern = pattern_q[rd_addr];
   assign rd_dwell   = dwell_q[rd_addr];

endmodule

// File: rtl/waveform_seq_ctrl.sv
// Plays a programmable {pattern, dwell} table out on waveform_gen's en/pattern
// inputs, one-shot or looping, with start/stop control.
module waveform_seq_ctrl import waveform_pkg::*; #(
   parameter int DEPTH = 4,
   parameter int AW    = 2,
   parameter int DW    = DW_DEFAULT
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cfg_we,
   input  logic [AW-1:0] cfg_addr,
   input  logic [1:0]    cfg_pattern,
   input  logic [DW-1:0] cfg_dwell,
   input  logic [AW:0]   cfg_len,
   input  logic          loop,
   input  logic          start,
   input  logic          stop,
   output logic          gen_en,
   output logic [1:0]    gen_pattern,
   output logic [AW-1:0] step_idx,
   output logic          busy,
   output logic          done
);

   localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

   state_t        state_q, state_d;
   logic [AW:0]   len_q, len_d;
   logic          loop_q, loop_d;
   logic [DW-1:0] cnt_q, cnt_d;
   logic [AW-1:0] idx_q, idx_d;
   logic          gen_en_q, gen_en_d;
   logic [1:0]    pattern_q, pattern_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;

   logic [AW-1:0] last_idx, next_idx, rd_addr;
   logic [1:0]    rd_pattern;
   logic [DW-1:0] rd_dwell;

   // A dwell of 0 behaves like 1: the counter counts down to zero inclusive.
   function automatic logic [DW-1:0] dwell_load(input logic [DW-1:0] d);
      return (d == '0) ? '0 : d - DW'(1);
   endfunction

   assign last_idx = AW'(len_q - (AW+1)'(1));
   assign next_idx = (idx_q == last_idx) ? '0 : idx_q + AW'(1);
   // In IDLE the read port looks at step 0 so start can load it directly.
   assign rd_addr  = (state_q == ST_RUN) ? next_idx : '0;

   waveform_seq_table #(
      .DEPTH (DEPTH),
      .AW    (AW),
      .DW    (DW)
   ) u_table (
      .clk        (clk),
      .rst        (rst),
      .we         (cfg_we && (state_q == ST_IDLE)),
      .wr_addr    (cfg_addr),
      .wr_pattern (cfg_pattern),
      .wr_dwell   (cfg_dwell),
      .rd_addr    (rd_addr),
      .rd_pattern (rd_pattern),
      .rd_dwell   (rd_dwell)
   );

   always_comb begin
      state_d   = state_q;
      len_d     = len_q;
      loop_d    = loop_q;
      cnt_d     = cnt_q;
      idx_d     = idx_q;
      gen_en_d  = gen_en_q;
      pattern_d = pattern_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            idx_d    = '0;
            gen_en_d = 1'b0;
            busy_d   = 1'b0;
            if (start && (cfg_len != '0)) begin
               state_d   = ST_RUN;
               len_d     = (cfg_len > DEPTH_L) ? DEPTH_L : cfg_len;
               loop_d    = loop;
               cnt_d     = dwell_load(rd_dwell);
               pattern_d = rd_pattern;
               gen_en_d  = 1'b1;
               busy_d    = 1'b1;
            end
         end
         ST_RUN: begin
            if (stop) begin
               state_d  = ST_IDLE;
               idx_d    = '0;
               gen_en_d = 1'b0;
               busy_d   = 1'b0;
            end else if (cnt_q != '0) begin
               cnt_d = cnt_q - DW'(1);
            end else if ((idx_q != last_idx) || loop_q) begin
               idx_d     = next_idx;
               cnt_d     = dwell_load(rd_dwell);
               pattern_d = rd_pattern;
            end else begin
               state_d  = ST_DONE;
               idx_d    = '0;
               gen_en_d = 1'b0;
               busy_d   = 1'b0;
               done_d   = 1'b1;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d  = ST_IDLE;
            idx_d    = '0;
            gen_en_d = 1'b0;
            busy_d   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         len_q     <= '0;
         loop_q    <= 1'b0;
         cnt_q     <= '0;
         idx_q     <= '0;
         gen_en_q  <= 1'b0;
         pattern_q <= PAT_0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         len_q     <= len_d;
         loop_q    <= loop_d;
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         gen_en_q  <= gen_en_d;
         pattern_q <= pattern_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign gen_en      = gen_en_q;
   assign gen_pattern = pattern_q;
   assign step_idx    = idx_q;
   assign busy        = busy_q;
   assign done        = done_q;

endmodule

// File: tb/tb_waveform_seq_ctrl.sv
// Scoreboard bench for waveform_seq_ctrl: directed per-cycle expectations are
// queued by the stimulus and checked by an independent monitor.
module tb_waveform_seq_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       cfg_we;
   logic [1:0] cfg_addr;
   logic [1:0] cfg_pattern;
   logic [7:0] cfg_dwell;
   logic [2:0] cfg_len;
   logic       loop;
   logic       start;
   logic       stop;
   logic       gen_en;
   logic [1:0] gen_pattern;
   logic [1:0] step_idx;
   logic       busy;
   logic       done;

   typedef struct {
      bit         chk;
      logic [6:0] exp;
      string      nm;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   bit   stim_done = 1'b0;

   always #5 clk = ~clk;

   waveform_seq_ctrl #(.DEPTH(4), .AW(2), .DW(8)) dut (
      .clk         (clk),
      .rst         (rst),
      .cfg_we      (cfg_we),
      .cfg_addr    (cfg_addr),
      .cfg_pattern (cfg_pattern),
      .cfg_dwell   (cfg_dwell),
      .cfg_len     (cfg_len),
      .loop        (loop),
      .start       (start),
      .stop        (stop),
      .gen_en      (gen_en),
      .gen_pattern (gen_pattern),
      .step_idx    (step_idx),
      .busy        (busy),
      .done        (done)
   );

   // Monitor: one expectation per clock edge, sampled 1 time unit after it.
   initial begin
      exp_t       e;
      logic [6:0] act;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            e   = sb.pop_front();
            act = {gen_en, gen_pattern, step_idx, busy, done};
            if (e.chk) begin
               checks++;
               if (act !== e.exp) begin
                  errors++;
                  $display("FAIL %s: got en/pat/idx/busy/done=%b required %b", e.nm, act, e.exp);
               end
            end
         end
      end
   end

   // Queue the outputs expected after the next edge, then let that edge pass.
   task automatic cyc(input logic en, input logic [1:0] pat, input logic [1:0] idx,
                      input logic bsy, input logic dn, input string nm);
      exp_t e;
      e.chk = 1'b1;
      e.exp = {en, pat, idx, bsy, dn};
      e.nm  = nm;
      sb.push_back(e);
      @(posedge clk);
      #2;
      cfg_we = 1'b0;
      start  = 1'b0;
      stop   = 1'b0;
   endtask

   task automatic wr(input logic [1:0] a, input logic [1:0] p, input logic [7:0] d,
                     input logic [1:0] hold_pat);
      cfg_we      = 1'b1;
      cfg_addr    = a;
      cfg_pattern = p;
      cfg_dwell   = d;
      cyc(1'b0, hold_pat, 2'd0, 1'b0, 1'b0, "wr_idle");
   endtask

   task automatic go(input logic [2:0] len, input logic lp);
      start   = 1'b1;
      cfg_len = len;
      loop    = lp;
   endtask

   initial begin
      rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_pattern = '0; cfg_dwell = '0;
      cfg_len = '0; loop = 1'b0; start = 1'b0; stop = 1'b0;

      // Reset and readback of the cleared table
      cyc(1'b0, 2'b00, 2'd0, 1'b0, 1'b0, "rst_c0");
      cyc(1'b0, 2'b00, 2'd0, 1'b0, 1'b0, "rst_c1");
      rst = 1'b0;
      go(3'd1, 1'b0);
      cyc(1'b1, 2'b00, 2'd0, 1'b1, 1'b0, "t1_run");
      cyc(1'b0, 2'b00, 2'd0, 1'b0, 1'b1, "t1_done");
      cyc(1'b0, 2'b00, 2'd0, 1'b0, 1'b0, "t1_idle");

      // One-shot playback
      wr(2'd0, 2'b10, 8'd3, 2'b00);
      wr(2'd1, 2'b01, 8'd1, 2'b00);
      wr(2'd2, 2'b11, 8'd2, 2'b00);
      go(3'd3, 1'b0);
      cyc(1'b1, 2'b10, 2'd0, 1'b1, 1'b0, "t2_s0a");
      cyc(1'b1, 2'b10, 2'd0, 1'b1, 1'b0, "t2_s0b");
      cyc(1'b1, 2'b10, 2'd0, 1'b1, 1'b0, "t2_s0c");
      cyc(1'b1, 2'b01, 2'd1, 1'b1, 1'b0, "t2_s1");
      cyc(1'b1, 2'b11, 2'd2, 1'b1, 1'b0, "t2_s2a");
      cyc(1'b1, 2'b11, 2'd2, 1'b1, 1'b0, "t2_s2b");
      cyc(1'b0, 2'b11, 2'd0, 1'b0, 1'b1, "t2_done");
      cyc(1'b0, 2'b11, 2'd0, 1'b0, 1'b0, "t2_idle");

      // Looping playback, then stop on a step-end cycle
      go(3'd3, 1'b1);
      cyc(1'b1, 2'b10, 2'd0, 1'b1, 1'b0, "t3_s0a");
      cyc(1'b1, 2'b10, 2'd0, 1'b1, 1'b0, "t3_s0b");
      cyc(1'b1, 2'b10, 2'd0, 1'b1, 1'b0, "t3_s0c");
      cyc(1'b1, 2'b01, 2'd1, 1'b1, 1'b0, "t3_s1");
      cyc(1'b1, 2'b11, 2'd2, 1'b1, 1'b0, "t3_s2a");
      cyc(1'b1, 2'b11, 2'd2, 1'b1, 1'b0, "t3_s2b");
      cyc(1'b1, 2'b10, 2'd0, 1'b1, 1'b0, "t3_wrap_a");
      cyc(1'b1, 2'b10, 2'd0, 1'b1, 1'b0, "t3_wrap_b");
      cyc(1'b1, 2'b10, 2'd0, 1'b1, 1'b0, "t3_wrap_c");
      stop = 1'b1;
      cyc(1'b0, 2'b10, 2'd0, 1'b0, 1'b0, "t3_stop");
      cyc(1'b0, 2'b10, 2'd0, 1'b0, 1'b0, "t3_idle");

      // Dwell 0 and length clamp to DEPTH
      wr(2'd0, 2'b01, 8'd0, 2'b10);
      wr(2'd3, 2'b10, 8'd1, 2'b10);
      go(3'd7, 1'b0);
      cyc(1'b1, 2'b01, 2'd0, 1'b1, 1'b0, "t4_s0");
      cyc(1'b1, 2'b01, 2'd1, 1'b1, 1'b0, "t4_s1");
      cyc(1'b1, 2'b11, 2'd2, 1'b1, 1'b0, "t4_s2a");
      cyc(1'b1, 2'b11, 2'd2, 1'b1, 1'b0, "t4_s2b");
      cyc(1'b1, 2'b10, 2'd3, 1'b1, 1'b0, "t4_s3");
      cyc(1'b0, 2'b10, 2'd0, 1'b0, 1'b1, "t4_done");
      cyc(1'b0, 2'b10, 2'd0, 1'b0, 1'b0, "t4_idle");

      // Lockout of writes and start while running
      go(3'd3, 1'b0);
      cyc(1'b1, 2'b01, 2'd0, 1'b1, 1'b0, "t5_s0");
      cfg_we = 1'b1; cfg_addr = 2'd1; cfg_pattern = 2'b00; cfg_dwell = 8'd5;
      cyc(1'b1, 2'b01, 2'd1, 1'b1, 1'b0, "t5_s1_we");
      go(3'd1, 1'b1);
      cyc(1'b1, 2'b11, 2'd2, 1'b1, 1'b0, "t5_s2a_st");
      cyc(1'b1, 2'b11, 2'd2, 1'b1, 1'b0, "t5_s2b");
      cyc(1'b0, 2'b11, 2'd0, 1'b0, 1'b1, "t5_done");
      cyc(1'b0, 2'b11, 2'd0, 1'b0, 1'b0, "t5_idle");
      go(3'd2, 1'b0);
      cyc(1'b1, 2'b01, 2'd0, 1'b1, 1'b0, "t5_rb_s0");
      cyc(1'b1, 2'b01, 2'd1, 1'b1, 1'b0, "t5_rb_s1");
      cyc(1'b0, 2'b01, 2'd0, 1'b0, 1'b1, "t5_rb_done");
      go(3'd0, 1'b0);
      cyc(1'b0, 2'b01, 2'd0, 1'b0, 1'b0, "t5_len0");
      cyc(1'b0, 2'b01, 2'd0, 1'b0, 1'b0, "t5_len0_b");

      // Reset in the middle of a run, then restart from step 0
      go(3'd3, 1'b1);
      cyc(1'b1, 2'b01, 2'd0, 1'b1, 1'b0, "t6_s0");
      cyc(1'b1, 2'b01, 2'd1, 1'b1, 1'b0, "t6_s1");
      rst = 1'b1;
      cyc(1'b0, 2'b00, 2'd0, 1'b0, 1'b0, "t6_rst");
      rst = 1'b0;
      cyc(1'b0, 2'b00, 2'd0, 1'b0, 1'b0, "t6_idle");
      go(3'd3, 1'b0);
      cyc(1'b1, 2'b00, 2'd0, 1'b1, 1'b0, "t6_r_s0");
      cyc(1'b1, 2'b00, 2'd1, 1'b1, 1'b0, "t6_r_s1");
      cyc(1'b1, 2'b00, 2'd2, 1'b1, 1'b0, "t6_r_s2");
      cyc(1'b0, 2'b00, 2'd0, 1'b0, 1'b1, "t6_r_done");
      cyc(1'b0, 2'b00, 2'd0, 1'b0, 1'b0, "t6_r_idle");

      repeat (2) @(posedge clk);
      #3;
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL sb_drain: got %0d pending entries required 0", sb.size());
      end
      stim_done = 1'b1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      if (!stim_done) begin
         $display("FAIL watchdog: got timeout required completion");
         $fatal(1, "watchdog expired");
      end
   end

endmodule
